counter_timer_ctrl: RTL and testbench

Programmable interval-timer controller built around a loadable up-counter datapath. It sequences the counter through clear, count and reload, and gates counting with a prescaler. It issues a periodic or one-shot `tick` to downstream logic. It sits between a host control interface (start/stop/config) and the lab datapath blocks that consume timing events.

---
 rtl/ctrl_pkg.sv | 13 +
 rtl/timer_prescaler.sv | 31 +++
 rtl/counter_timer_ctrl.sv | 87 ++++++++
 tb/tb_counter_timer_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the interval-timer controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: emits one step strobe every (prescale_s+1) enabled clocks.
module timer_prescaler #(
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [PRE_WIDTH-1:0] prescale_s,
    output logic                 step
);

    logic [PRE_WIDTH-1:0] pre;
    logic                 at_limit;

    assign at_limit = (pre == prescale_s);
    assign step     = enable && !clear && at_limit;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches synthesis.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre <= '0;
        end else if (clear) begin
            pre <= '0;
        end else if (enable) begin
            pre <= at_limit ? '0 : pre + PRE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Interval-timer controller: FSM, shadow config registers and main up-counter.
module counter_timer_ctrl
    import ctrl_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int PRE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     period,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]     cnt_out,
    output logic                 busy,
    output logic                 tick,
    output logic                 done
);

    state_t               state;
    logic [WIDTH-1:0]     period_s;
    logic [PRE_WIDTH-1:0] prescale_s;
    logic                 mode_s;
    logic                 step;

    // Any control request restarts the prescale phase from zero.
    timer_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clear      (start | stop),
        .enable     (state == RUN),
        .prescale_s (prescale_s),
        .step       (step)
    );

    // NOTE: shadow config registers are reset explicitly; they are small
    // flops, not a memory, and a defined value keeps restarts deterministic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt_out    <= '0;
            period_s   <= '0;
            prescale_s <= '0;
            mode_s     <= MODE_ONESHOT;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                period_s   <= period;
                prescale_s <= prescale;
                mode_s     <= mode;
                cnt_out    <= '0;
                state      <= RUN;
                busy       <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (step) begin
                            if (cnt_out != period_s) begin
                                cnt_out <= cnt_out + WIDTH'(1);
                            end else begin
                                tick <= 1'b1;
                                if (mode_s == MODE_PERIODIC) begin
                                    cnt_out <= '0;
                                end else begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed self-checking bench for counter_timer_ctrl using an expected-value queue.
module tb_counter_timer_ctrl;

    localparam int WIDTH     = 5;
    localparam int PRE_WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] cnt;
        logic             busy;
        logic             tick;
        logic             done;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start, stop, mode;
    logic [WIDTH-1:0]     period;
    logic [PRE_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]     cnt_out;
    logic                 busy, tick, done;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    counter_timer_ctrl #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .period   (period),
        .prescale (prescale),
        .cnt_out  (cnt_out),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".cnt"},  32'(cnt_out), 32'(e.cnt));
        check({tag, ".busy"}, 32'(busy),    32'(e.busy));
        check({tag, ".tick"}, 32'(tick),    32'(e.tick));
        check({tag, ".done"}, 32'(done),    32'(e.done));
    endtask

    // Push expectation for the upcoming edge, then pop and compare #1 after it.
    task automatic cycle(input string tag, input exp_t e);
        exp_t got;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_outputs(tag, got);
    endtask

    function automatic exp_t mk(input int c, input bit b, input bit t, input bit d);
        exp_t e;
        e.cnt  = WIDTH'(c);
        e.busy = b;
        e.tick = t;
        e.done = d;
        return e;
    endfunction

    // Closed-form expectation k edges after a start edge.
    function automatic exp_t model(input int per, input int pre, input bit periodic, input int k);
        int n    = k / (pre + 1);
        int term = (per + 1) * (pre + 1);
        if (periodic)
            return mk(n % (per + 1), 1'b1, (k > 0) && (k % term == 0), 1'b0);
        if (k < term)  return mk(n, 1'b1, 1'b0, 1'b0);
        if (k == term) return mk(per, 1'b0, 1'b1, 1'b1);
        return mk(per, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic do_start(input string tag, input bit m, input int per, input int pre);
        start    = 1'b1;
        mode     = m;
        period   = WIDTH'(per);
        prescale = PRE_WIDTH'(pre);
        cycle(tag, model(per, pre, m, 0));
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = '0; prescale = '0;

        #3;
        check_outputs("reset", mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle("idle_after_reset", mk(0, 0, 0, 0));

        // Periodic period=3 prescale=0; config change mid-run must be ignored.
        do_start("per3_start", 1'b1, 3, 0);
        for (int k = 1; k <= 13; k++) begin
            if (k == 6) period = WIDTH'(1);
            cycle($sformatf("per3_k%0d", k), model(3, 0, 1'b1, k));
        end
        stop = 1'b1;
        cycle("per3_stop", mk(1, 0, 0, 0));
        stop = 1'b0;
        cycle("per3_idle", mk(1, 0, 0, 0));

        // One-shot period=2 prescale=1.
        do_start("os_start", 1'b0, 2, 1);
        for (int k = 1; k <= 9; k++)
            cycle($sformatf("os_k%0d", k), model(2, 1, 1'b0, k));

        // period=0 prescale=2 periodic.
        do_start("p0_start", 1'b1, 0, 2);
        for (int k = 1; k <= 9; k++)
            cycle($sformatf("p0_k%0d", k), model(0, 2, 1'b1, k));

        // Restart from RUN, then restart again at cnt_out=2 with new config.
        do_start("rs_a_start", 1'b1, 5, 0);
        for (int k = 1; k <= 2; k++)
            cycle($sformatf("rs_a_k%0d", k), model(5, 0, 1'b1, k));
        do_start("rs_b_start", 1'b1, 2, 1);
        for (int k = 1; k <= 6; k++)
            cycle($sformatf("rs_b_k%0d", k), model(2, 1, 1'b1, k));

        // start and stop together in RUN: stop wins, count held.
        do_start("ss_start", 1'b1, 2, 1);
        for (int k = 1; k <= 5; k++)
            cycle($sformatf("ss_k%0d", k), model(2, 1, 1'b1, k));
        start = 1'b1; stop = 1'b1; period = WIDTH'(7);
        cycle("ss_both", mk(2, 0, 0, 0));
        start = 1'b0; stop = 1'b0;
        cycle("ss_idle", mk(2, 0, 0, 0));

        // Restart exactly at terminal count suppresses the tick.
        do_start("sup_start", 1'b1, 1, 0);
        cycle("sup_k1", model(1, 0, 1'b1, 1));
        do_start("sup_restart", 1'b1, 1, 0);
        for (int k = 1; k <= 2; k++)
            cycle($sformatf("sup_k%0d_b", k), model(1, 0, 1'b1, k));

        // Asynchronous reset mid-RUN while tick is high.
        do_start("rst_start", 1'b1, 3, 0);
        for (int k = 1; k <= 4; k++)
            cycle($sformatf("rst_k%0d", k), model(3, 0, 1'b1, k));
        #2;
        rst = 1'b0;
        #1;
        check_outputs("rst_async", mk(0, 0, 0, 0));
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 6; k++)
            cycle($sformatf("rst_post_k%0d", k), mk(0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
